// File: rtl/crc_rx_arbiter_pkg.sv
// Shared constants and the CRC-8 remainder helper for the receive-side
// CRC arbiter. The codeword is right-aligned in a fixed-width container;
// leading zeros do not change a remainder that starts from zero.
package crc_rx_pkg;

  localparam int          CRC_BW     = 8;
  localparam logic [7:0]  CRC_POLY   = 8'h07;
  localparam int          CRC_CW_MAX = 72;

  // Remainder of the whole codeword divided by x^8+x^2+x+1 (0x107),
  // one bit per step, MSB first.
  function automatic logic [7:0] crc8_rem(input logic [CRC_CW_MAX-1:0] codeword);
    logic [7:0] rem;
    logic       fb;
    rem = 8'h00;
    fb  = 1'b0;
    for (int i = CRC_CW_MAX - 1; i >= 0; i--) begin
      fb  = rem[7];
      rem = {rem[6:0], codeword[i]};
      if (fb) begin
        rem = rem ^ CRC_POLY;
      end else begin
        rem = rem;
      end
    end
    return rem;
  endfunction

endpackage

// File: rtl/crc_rx_arbiter_if.sv
// Requester and consumer handshake bundle of the CRC receive arbiter.
// master = the traffic side (deframers + consumer), slave = the arbiter.
interface crc_rx_arbiter_if #(
  parameter int BW   = 40,
  parameter int N_CH = 2
);
  import crc_rx_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]               in_valid;
  logic [N_CH-1:0]               in_ready;
  logic [N_CH*(BW+CRC_BW)-1:0]   in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [BW-1:0]                 out_data;
  logic                          out_ok;
  logic [CH_W-1:0]               out_ch;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ok, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ok, out_ch
  );

endinterface

// File: rtl/crc_rx_arbiter_crc8_check.sv
// Combinational CRC-8 pass/fail check of one {payload, crc} codeword.
module crc8_check
  import crc_rx_pkg::*;
#(
  parameter int BW = 40
) (
  input  logic [BW+CRC_BW-1:0] codeword,
  output logic                 ok
);

  assign ok = (crc8_rem(CRC_CW_MAX'(codeword)) == 8'h00);

endmodule

// File: rtl/crc_rx_arbiter.sv
// Round-robin arbiter sharing one CRC-8 checker among N_CH requesters,
// with a single registered output stage and saturating error counters.
module crc_rx_arbiter
  import crc_rx_pkg::*;
#(
  parameter int BW       = 40,
  parameter int N_CH     = 2,
  parameter int CNT_W    = 16,
  parameter bit DROP_BAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  crc_rx_arbiter_if.slave       bus,
  input  logic                  clr_cnt,
  output logic [N_CH*CNT_W-1:0] err_cnt
);

  localparam int              CW      = BW + CRC_BW;
  localparam int              CH_W    = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CH_W-1:0]  r_rr;
  logic             r_out_valid;
  logic [BW-1:0]    r_out_data;
  logic             r_out_ok;
  logic [CH_W-1:0]  r_out_ch;
  logic [CNT_W-1:0] r_cnt [N_CH];

  logic [CW-1:0]    w_cw_arr [N_CH];
  logic             w_any;
  logic [CH_W-1:0]  w_idx;
  logic [CH_W:0]    w_c;
  logic [CW-1:0]    w_cw;
  logic             w_ok;
  logic             w_slot_free;
  logic             w_take;
  logic             w_load;
  logic [CH_W-1:0]  w_rr_next;

  // Split the flat codeword bus into one word per channel.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_cw_arr[c] = bus.in_data[c*CW +: CW];
    end
  end

  // Search requesters starting at the pointer; the first valid one wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_c   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_c = {1'b0, r_rr} + (CH_W+1)'(i);
      if (w_c >= (CH_W+1)'(N_CH)) begin
        w_c = w_c - (CH_W+1)'(N_CH);
      end else begin
        w_c = w_c;
      end
      if (!w_any && bus.in_valid[w_c[CH_W-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_c[CH_W-1:0];
      end else begin
        w_any = w_any;
        w_idx = w_idx;
      end
    end
  end

  assign w_cw = w_cw_arr[w_idx];

  crc8_check #(.BW(BW)) u_crc (
    .codeword (w_cw),
    .ok       (w_ok)
  );

  // A bad word under DROP_BAD never needs the output slot, so it is always taken.
  assign w_slot_free = ~r_out_valid | bus.out_ready;
  assign w_take      = rstn & w_any & (w_slot_free | (DROP_BAD & ~w_ok));
  assign w_load      = w_take & (w_ok | ~DROP_BAD);
  assign w_rr_next   = (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + CH_W'(1);

  // Grant is one-hot on the winning channel only when the transfer can happen.
  always_comb begin
    bus.in_ready = '0;
    if (w_take) begin
      bus.in_ready[w_idx] = 1'b1;
    end else begin
      bus.in_ready = '0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ok    = r_out_ok;
  assign bus.out_ch    = r_out_ch;

  // Output stage: load on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ok    <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_cw[CW-1:CRC_BW];
      r_out_ok    <= w_ok;
      r_out_ch    <= w_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Round-robin pointer moves past the winner only on an accepted transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr <= '0;
    end else if (w_take) begin
      r_rr <= w_rr_next;
    end else begin
      r_rr <= r_rr;
    end
  end

  // Per-channel saturating error counters; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < N_CH; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (clr_cnt) begin
          r_cnt[c] <= '0;
        end else if (w_take && !w_ok && (w_idx == CH_W'(c)) && (r_cnt[c] != CNT_MAX)) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end else begin
          r_cnt[c] <= r_cnt[c];
        end
      end
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    err_cnt = '0;
    for (int c = 0; c < N_CH; c++) begin
      err_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
    end
  end

endmodule

// File: tb/tb_crc_rx_arbiter.sv
// Bench for crc_rx_arbiter: a directed vector table and a randomized run
// against a reference model on a 3-channel instance, plus a hand-written
// sequence on a 2-channel DROP_BAD instance with 2-bit counters.
module tb_crc_rx_arbiter;

  localparam logic [47:0] G1 = 48'h000000000107;
  localparam logic [47:0] GF = 48'h00000000FFF3;
  localparam logic [47:0] Z  = 48'h000000000000;
  localparam logic [47:0] B  = 48'h000000000106;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr_a, clr_b;
  logic [47:0] err_cnt_a;
  logic [3:0]  err_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc_rx_arbiter_if #(.BW(40), .N_CH(3)) bus_a ();
  crc_rx_arbiter_if #(.BW(40), .N_CH(2)) bus_b ();

  crc_rx_arbiter #(.BW(40), .N_CH(3), .CNT_W(16), .DROP_BAD(1'b0)) u_dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a.slave), .clr_cnt(clr_a), .err_cnt(err_cnt_a)
  );

  crc_rx_arbiter #(.BW(40), .N_CH(2), .CNT_W(2), .DROP_BAD(1'b1)) u_dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b.slave), .clr_cnt(clr_b), .err_cnt(err_cnt_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // GF(2) long division of a 48-bit codeword by 0x107.
  function automatic logic [7:0] ref_rem(input logic [47:0] cw);
    logic [47:0] v;
    v = cw;
    for (int b = 47; b >= 8; b--) begin
      if (v[b]) v = v ^ (48'h107 << (b - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [47:0] gen_cw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 1) == 1) return {r[39:0], ref_rem({r[39:0], 8'h00})};
    else return {r[39:0], r[47:40]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [47:0] d0;
    logic [47:0] d1;
    logic        ordy;
    logic        clr;
    logic [2:0]  rdy;
    logic        ov;
    logic [1:0]  ch;
    logic        ok;
    logic [39:0] dat;
    logic [15:0] c1;
  } vec_t;

  vec_t tbl [17];

  task automatic step_b(input string nm, input logic [1:0] v, input logic [47:0] d0,
                        input logic [47:0] d1, input logic ordy, input logic clr,
                        input logic [1:0] erdy, input logic eov, input logic ech,
                        input logic [39:0] edat, input logic eok,
                        input logic [1:0] ec0, input logic [1:0] ec1);
    bus_b.in_valid  = v;
    bus_b.in_data   = {d1, d0};
    bus_b.out_ready = ordy;
    clr_b           = clr;
    #1;
    chk({nm, " rdy"}, bus_b.in_ready, erdy);
    tick();
    chk({nm, " ov"}, bus_b.out_valid, eov);
    chk({nm, " ch"}, bus_b.out_ch, ech);
    chk({nm, " dat"}, bus_b.out_data, edat);
    chk({nm, " ok"}, bus_b.out_ok, eok);
    chk({nm, " cnt0"}, err_cnt_b[1:0], ec0);
    chk({nm, " cnt1"}, err_cnt_b[3:2], ec1);
  endtask

  // reference model state for the randomized run
  int          m_rr, m_ch, g;
  logic        m_ov, m_ok, ok_g, ordy;
  logic [39:0] m_data;
  int          m_cnt [3];
  logic        pend [3];
  logic [47:0] pdata [3];
  logic [2:0]  exp_rdy;

  initial begin
    tbl[0]  = '{3'b001, G1, Z, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 40'h01, 16'd0};
    tbl[1]  = '{3'b011, GF, Z, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1, 1'b1, 40'h00, 16'd0};
    tbl[2]  = '{3'b011, GF, Z, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 40'hFF, 16'd0};
    tbl[3]  = '{3'b011, GF, Z, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1, 1'b1, 40'h00, 16'd0};
    tbl[4]  = '{3'b011, GF, Z, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 40'hFF, 16'd0};
    tbl[5]  = '{3'b010, Z,  B, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1, 1'b0, 40'h01, 16'd1};
    tbl[6]  = '{3'b001, GF, Z, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 40'hFF, 16'd1};
    for (int i = 7; i < 12; i++)
      tbl[i] = '{3'b001, G1, Z, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 40'hFF, 16'd1};
    tbl[12] = '{3'b001, G1, Z, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1, 40'h01, 16'd1};
    tbl[13] = '{3'b000, Z,  Z, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 40'h01, 16'd1};
    tbl[14] = '{3'b000, Z,  Z, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1, 40'h01, 16'd1};
    tbl[15] = '{3'b010, Z,  B, 1'b1, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 40'h01, 16'd0};
    tbl[16] = '{3'b000, Z,  Z, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 1'b0, 40'h01, 16'd0};

    rstn = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_a.in_valid = 3'b111; bus_b.in_valid = 2'b11;
    #1;
    chk("rst rdy_a", bus_a.in_ready, 64'h0);
    chk("rst rdy_b", bus_b.in_ready, 64'h0);
    chk("rst ov_a", bus_a.out_valid, 64'h0);
    chk("rst dat_a", bus_a.out_data, 64'h0);
    chk("rst ok_a", bus_a.out_ok, 64'h0);
    chk("rst ch_a", bus_a.out_ch, 64'h0);
    chk("rst cnt_a", err_cnt_a, 64'h0);
    chk("rst ov_b", bus_b.out_valid, 64'h0);
    chk("rst cnt_b", err_cnt_b, 64'h0);
    bus_a.in_valid = '0; bus_b.in_valid = '0;
    rstn = 1'b1;

    // table-driven directed vectors on instance A
    for (int i = 0; i < 17; i++) begin
      bus_a.in_valid  = tbl[i].v;
      bus_a.in_data   = {Z, tbl[i].d1, tbl[i].d0};
      bus_a.out_ready = tbl[i].ordy;
      clr_a           = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d rdy", i), bus_a.in_ready, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d ov", i), bus_a.out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d ch", i), bus_a.out_ch, tbl[i].ch);
      chk($sformatf("tbl%0d ok", i), bus_a.out_ok, tbl[i].ok);
      chk($sformatf("tbl%0d dat", i), bus_a.out_data, tbl[i].dat);
      chk($sformatf("tbl%0d cnt1", i), err_cnt_a[31:16], tbl[i].c1);
    end
    bus_a.in_valid = '0; clr_a = 1'b0;

    // DROP_BAD instance: bad words bypass a stalled output, counters saturate
    step_b("b1", 2'b10, Z,  GF, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd0, 2'd0);
    step_b("b2", 2'b01, B,  Z,  1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd1, 2'd0);
    step_b("b3", 2'b01, B,  Z,  1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd2, 2'd0);
    step_b("b4", 2'b01, B,  Z,  1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd3, 2'd0);
    step_b("b5", 2'b01, B,  Z,  1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd3, 2'd0);
    step_b("b6", 2'b01, B,  Z,  1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd0, 2'd0);
    step_b("b7", 2'b01, G1, Z,  1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 40'hFF, 1'b1, 2'd0, 2'd0);
    step_b("b8", 2'b01, G1, Z,  1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 40'h01, 1'b1, 2'd0, 2'd0);
    step_b("b9", 2'b01, B,  Z,  1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 40'h01, 1'b1, 2'd1, 2'd0);
    step_b("b10", 2'b11, B, B,  1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 40'h01, 1'b1, 2'd1, 2'd1);
    bus_b.in_valid = '0; clr_b = 1'b0;

    // randomized run on instance A against the reference model
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    m_rr = 0; m_ov = 1'b0; m_data = '0; m_ok = 1'b0; m_ch = 0;
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0; pend[c] = 1'b0; pdata[c] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 55) begin
          pend[c]  = 1'b1;
          pdata[c] = gen_cw();
        end
      end
      ordy = ($urandom_range(0, 99) < 65);
      bus_a.in_valid  = {pend[2], pend[1], pend[0]};
      bus_a.in_data   = {pdata[2], pdata[1], pdata[0]};
      bus_a.out_ready = ordy;
      clr_a           = ($urandom_range(0, 99) < 3);
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && pend[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      end
      exp_rdy = 3'b000;
      ok_g    = 1'b0;
      if (g >= 0) begin
        ok_g = (ref_rem(pdata[g]) == 8'h00);
        if (!m_ov || ordy) exp_rdy = 3'b001 << g;
      end
      #1;
      chk($sformatf("rnd%0d rdy", cyc), bus_a.in_ready, exp_rdy);
      for (int c = 0; c < 3; c++) begin
        if (clr_a) m_cnt[c] = 0;
        else if (exp_rdy != 3'b000 && g == c && !ok_g && m_cnt[c] < 65535) m_cnt[c]++;
      end
      if (exp_rdy != 3'b000) begin
        m_ov = 1'b1; m_data = pdata[g][47:8]; m_ok = ok_g; m_ch = g;
        m_rr = (g + 1) % 3;
        pend[g] = 1'b0;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      tick();
      chk($sformatf("rnd%0d ov", cyc), bus_a.out_valid, m_ov);
      chk($sformatf("rnd%0d dat", cyc), bus_a.out_data, m_data);
      chk($sformatf("rnd%0d ok", cyc), bus_a.out_ok, m_ok);
      chk($sformatf("rnd%0d ch", cyc), bus_a.out_ch, m_ch);
      for (int c = 0; c < 3; c++)
        chk($sformatf("rnd%0d cnt%0d", cyc, c), err_cnt_a[c*16 +: 16], m_cnt[c]);
    end
    clr_a = 1'b0;

    // reset while a word sits in the output: word lost, arbitration restarts at 0
    bus_a.in_valid = 3'b001; bus_a.in_data = {Z, Z, B}; bus_a.out_ready = 1'b1;
    tick();
    chk("mrst pre ov", bus_a.out_valid, 64'h1);
    chk("mrst pre cnt0", err_cnt_a[15:0] != 16'h0, 64'h1);
    bus_a.in_valid = 3'b011; bus_a.in_data = {Z, GF, G1}; bus_a.out_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mrst rdy", bus_a.in_ready, 64'h0);
    chk("mrst ov", bus_a.out_valid, 64'h0);
    chk("mrst dat", bus_a.out_data, 64'h0);
    chk("mrst cnt", err_cnt_a, 64'h0);
    tick();
    chk("mrst rdy hold", bus_a.in_ready, 64'h0);
    rstn = 1'b1;
    #1;
    chk("mrst rel rdy", bus_a.in_ready, 64'h1);
    tick();
    chk("mrst rel ov", bus_a.out_valid, 64'h1);
    chk("mrst rel ch", bus_a.out_ch, 64'h0);
    chk("mrst rel dat", bus_a.out_data, 64'h1);
    bus_a.in_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc_rx_arbiter.md
# crc_rx_arbiter

Round-robin arbiter and sequencer that shares one CRC-8 check datapath among `N_CH` codeword requesters on the receive side. It accepts `BW+CRC_BW`-bit codewords over per-channel valid/ready handshakes and checks the CRC of the granted codeword. It then presents the payload, a pass/fail flag and the source channel on one registered output stream. It also keeps saturating per-channel error counters. It sits between the channel deframers and the payload consumer, and replaces direct instantiation of one receiver per channel.

## Interface
- `BW`, 40, payload bits per codeword
- `CRC_BW`, 8, CRC bits; fixed at 8 (polynomial 0x07)
- `N_CH`, 2, number of requester channels (2..8)
- `CNT_W`, 16, error counter width per channel
- `DROP_BAD`, 0, if 1 then failing codewords are consumed and counted but never presented at the output
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset; one clock, asynchronous, active-low
- `in_valid`  in  N_CH  per-channel codeword valid
- `in_ready`  out  N_CH  per-channel accept (one-hot or zero)
- `in_data`  in  N_CH*(BW+CRC_BW)  channel c occupies bits [c*(BW+CRC_BW) +: BW+CRC_BW]; codeword = {payload, crc}
- `out_valid`  out  1  output holds a checked codeword
- `out_ready`  in  1  consumer accepts output
- `out_data`  out  BW  payload
- `out_ok`  out  1  1 = CRC remainder zero
- `out_ch`  out  $clog2(N_CH)  source channel
- `clr_cnt`  in  1  synchronous clear of all error counters
- `err_cnt`  out  N_CH*CNT_W  channel c at [c*CNT_W +: CNT_W]

## Operation
- CRC: CRC-8 with polynomial x^8+x^2+x+1 (0x07), init 0, no reflection, no final XOR. The codeword passes when the remainder of all BW+CRC_BW bits divided by 0x107 is 0.
- Arbitration: round-robin pointer `rr` (reset 0). Search begins at channel `(last_granted+1) mod N_CH`; the first channel with `in_valid` set wins. `rr` advances only on an accepted transfer.
- `in_ready[c]` = grant[c] & slot_free, where slot_free = !out_valid | out_ready (or DROP_BAD path below). At most one bit set. Ready depends combinationally on out_ready and in_valid; no path runs from in_ready back to in_valid.
- Accept (in_valid[c] & in_ready[c]): the CRC check runs combinationally on the granted codeword. On the next edge, out_data / out_ok / out_ch are loaded and out_valid is set to 1.
- DROP_BAD=1 with a failing codeword: the transfer is accepted and counted, out_valid is not set by it, and the output register keeps its current contents. Bad words are always accepted regardless of the output slot, which keeps bad traffic from stalling.
- Output holds stable while out_valid & !out_ready. out_valid clears on out_ready if no new accept occurs in the same cycle.
- Error counter c increments on each accepted failing codeword from channel c and saturates at 2^CNT_W-1.
- clr_cnt takes priority: if clr_cnt and an error occur in the same cycle, the counter ends at 0.
- Senders must hold in_valid/in_data until accepted. The arbiter does not re-arbitrate away from a held request; a grant is recomputed every cycle, but fairness follows from the pointer.

## Timing
- Reset values: out_valid 0, out_data 0, out_ok 0, out_ch 0, err_cnt all 0, rr 0. in_ready is 0 while rstn is low.
- Latency: accept at edge k gives out_valid at edge k+1 (1 cycle).
- Throughput: 1 codeword/cycle when out_ready is held high.
- Simultaneous out_ready and new accept: the output is replaced back-to-back with no bubble.
- Reset asserted mid-transfer: the output word is lost, counters clear, and arbitration restarts at channel 0.
- All requesters idle: in_ready is 0, rr is unchanged, out_valid follows the drain rule.

## Structure
- Package `crc_rx_pkg`: CRC_POLY = 8'h07, CRC_BW = 8, and function `crc8_rem(codeword)` (parameterised width via a loop bound constant).
- Sub-module `crc8_check`: combinational, input BW+CRC_BW, output `ok`. The arbiter instantiates one of it on the mux output.
- Arbiter, output register and counters live in the top. No FIFO.

## Test plan
- Reset, then ch0 sends 0x000000000107 with out_ready=1 → one cycle later out_valid=1, out_data=0x0000000001, out_ok=1, out_ch=0; err_cnt all 0.
- ch0 and ch1 held valid continuously with 0x00000000FFF3 and 0x000000000000, out_ready=1 → out_ch alternates 0,1,0,1; every out_ok=1.
- ch1 sends 0x000000000106 (bit flip), DROP_BAD=0 → out_ok=0, out_ch=1, and ch1's err_cnt goes 0→1 the cycle after the accept.
- out_ready held 0 for 5 cycles with ch0 valid → the first word is held stable, in_ready=0, and no second accept occurs. When out_ready rises, the next word appears the following cycle.
- DROP_BAD=1, ch0 sends the bad word 0x000000000106 while the output holds a good word with out_ready=0 → the bad word is accepted, err_cnt[0]=1, and the output is unchanged.
- CNT_W=2, four bad words on ch0 → the count saturates at 3. clr_cnt asserted in the same cycle as a fifth error → the count reads 0.
